// File: rtl/i2c_target_regfile.sv
// I2C target exposing DEPTH 8-bit registers through an auto-incrementing pointer; optional glitch filter via `I2C_TARGET_REGFILE_FILTER_EN.
// Latency: pads reach edge detection after a 2-FF sync (+2 clk with the filter); sda_oe moves 1 clk after the synchronized SCL fall.
// Backpressure: none; the controller paces the bus and ACK/NACK is the only flow control.
module i2c_target_regfile #(
  parameter logic [6:0] I2C_ADDR = 7'h50,
  parameter int         DEPTH    = 16,
  parameter int         PW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe,
  output logic          wr_stb,
  output logic [PW-1:0] wr_ptr,
  output logic [7:0]    wr_data,
  input  logic [PW-1:0] host_addr,
  output logic [7:0]    host_data,
  output logic          busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RD_ACK, WAIT
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    scl_sync, sda_sync;
  logic          scl_s, sda_s, scl_q, sda_q;
  logic          scl_rise, scl_fall, start, stop;
  logic [7:0]    shift;
  logic [3:0]    cnt;
  logic          cnt_done;
  logic          mack_sda;
  logic [PW-1:0] ptr, ptr_inc;
  logic [7:0]    regs [DEPTH];
  logic          addr_match, wr_commit;
  logic [7:0]    wr_byte;

  // Two-flop synchronizers; reset to 1 so the bus looks idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
    end
  end

`ifdef I2C_TARGET_REGFILE_FILTER_EN
  logic [1:0] scl_hist, sda_hist;
  logic       scl_flt, sda_flt;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // 3-sample majority vote: a level must persist two samples to pass, so single-clk pulses vanish
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_hist <= 2'b11;
      sda_hist <= 2'b11;
      scl_flt  <= 1'b1;
      sda_flt  <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[0], scl_sync[1]};
      sda_hist <= {sda_hist[0], sda_sync[1]};
      scl_flt  <= maj3(scl_sync[1], scl_hist[0], scl_hist[1]);
      sda_flt  <= maj3(sda_sync[1], sda_hist[0], sda_hist[1]);
    end
  end

  assign scl_s = scl_flt;
  assign sda_s = sda_flt;
`else
  assign scl_s = scl_sync[1];
  assign sda_s = sda_sync[1];
`endif

  // Previous-sample registers for edge and START/STOP detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_s;
      sda_q <= sda_s;
    end
  end

  assign scl_rise   = scl_s & ~scl_q;
  assign scl_fall   = ~scl_s & scl_q;
  assign start      = scl_s & scl_q & sda_q & ~sda_s;
  assign stop       = scl_s & scl_q & ~sda_q & sda_s;
  assign cnt_done   = (cnt == 4'd8);
  assign addr_match = (shift[7:1] == I2C_ADDR);
  assign ptr_inc    = ptr + PW'(1);
  assign wr_byte    = {shift[6:0], sda_s};
  assign wr_commit  = (state == WDATA) && scl_rise && (cnt == 4'd7) && !start && !stop;
  assign host_data  = regs[host_addr];

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state: bus conditions override everything, bytes advance on the SCL fall after bit 8
  always_comb begin
    state_nxt = state;
    if (stop) begin
      state_nxt = IDLE;
    end else if (start) begin
      state_nxt = ADDR;
    end else begin
      case (state)
        ADDR:      if (scl_fall && cnt_done) state_nxt = addr_match ? ADDR_ACK : WAIT;
        ADDR_ACK:  if (scl_fall) state_nxt = shift[0] ? RDATA : PTR;
        PTR:       if (scl_fall && cnt_done) state_nxt = PTR_ACK;
        PTR_ACK:   if (scl_fall) state_nxt = WDATA;
        WDATA:     if (scl_fall && cnt_done) state_nxt = WDATA_ACK;
        WDATA_ACK: if (scl_fall) state_nxt = WDATA;
        RDATA:     if (scl_fall && cnt_done) state_nxt = RD_ACK;
        RD_ACK:    if (scl_fall) state_nxt = mack_sda ? WAIT : RDATA;
        default:   state_nxt = state;
      endcase
    end
  end

  // FSM output: pull SDA for our ACK slots and for zero bits of read data
  always_comb begin
    sda_oe = 1'b0;
    case (state)
      ADDR_ACK, PTR_ACK, WDATA_ACK: sda_oe = 1'b1;
      RDATA:                        sda_oe = ~shift[7];
      default:                      sda_oe = 1'b0;
    endcase
  end

  // Datapath: bit capture/shift-out, pointer, register file and write strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift    <= '0;
      cnt      <= '0;
      mack_sda <= 1'b1;
      ptr      <= '0;
      wr_stb   <= 1'b0;
      wr_ptr   <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      wr_stb <= 1'b0;
      if (start || stop) begin
        cnt <= '0;
      end else begin
        case (state)
          ADDR, PTR, WDATA: begin
            if (scl_rise && !cnt_done) begin
              shift <= wr_byte;
              cnt   <= cnt + 4'd1;
            end
          end
          RDATA: begin
            if (scl_rise && !cnt_done) cnt <= cnt + 4'd1;
            if (scl_fall && !cnt_done) shift <= {shift[6:0], 1'b0};
          end
          RD_ACK: if (scl_rise) mack_sda <= sda_s;
          default: ;
        endcase
        // Every byte or ACK phase starts counting from zero
        if (state_nxt != state) cnt <= '0;
      end

      if (state == PTR && state_nxt == PTR_ACK) ptr <= shift[PW-1:0];

      if (wr_commit) begin
        regs[ptr] <= wr_byte;
        wr_stb    <= 1'b1;
        wr_ptr    <= ptr;
        wr_data   <= wr_byte;
        ptr       <= ptr_inc;
      end

      if (state == ADDR_ACK && state_nxt == RDATA) shift <= regs[ptr];

      if (state == RD_ACK && state_nxt == RDATA) begin
        ptr   <= ptr_inc;
        shift <= regs[ptr_inc];
      end

      if (stop) busy <= 1'b0;
      else if (state == ADDR && state_nxt == ADDR_ACK) busy <= 1'b1;
    end
  end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench for i2c_target_regfile: bus-level controller model with hand-computed expectations.
// Latency: controller runs a 20-clk SCL period, well above the 10x clk ratio.
// Backpressure: n/a; the bench is the bus controller.
module tb_i2c_target_regfile;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_drv, sda_drv;
  logic       sda_oe, wr_stb, busy;
  logic [3:0] wr_ptr, host_addr;
  logic [7:0] wr_data, host_data;
  logic       sda_line;

  int checks = 0;
  int errors = 0;

  logic [11:0] wr_log [$];
  logic        oe_seen;
  logic [7:0]  prev_hd, cap_old, cap_new;

  assign sda_line = sda_drv & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_regfile #(.I2C_ADDR(7'h50), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .scl_i(scl_drv), .sda_i(sda_line), .sda_oe(sda_oe),
    .wr_stb(wr_stb), .wr_ptr(wr_ptr), .wr_data(wr_data),
    .host_addr(host_addr), .host_data(host_data), .busy(busy)
  );

  // Record committed writes and watch the SDA driver
  always @(negedge clk) begin
    if (wr_stb) begin
      wr_log.push_back({wr_ptr, wr_data});
      if (wr_ptr == host_addr) begin
        cap_old = prev_hd;
        cap_new = host_data;
      end
    end
    if (sda_oe) oe_seen = 1'b1;
    prev_hd = host_data;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic q();
    repeat (5) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_drv = 1'b1; scl_drv = 1'b1; q();
    sda_drv = 1'b0; q();
    scl_drv = 1'b0; q();
  endtask

  task automatic i2c_rstart();
    sda_drv = 1'b1; q();
    scl_drv = 1'b1; q();
    sda_drv = 1'b0; q();
    scl_drv = 1'b0; q();
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0; q();
    scl_drv = 1'b1; q();
    sda_drv = 1'b1; q(); q();
  endtask

  // glitch_bit selects a bit whose high phase gets a 1-clk low pulse (-1 = none)
  task automatic write_byte(input logic [7:0] b, input int glitch_bit, output logic acked);
    for (int i = 7; i >= 0; i--) begin
      sda_drv = b[i]; q();
      scl_drv = 1'b1;
      if (i == glitch_bit) begin
        repeat (4) @(negedge clk);
        scl_drv = 1'b0;
        @(negedge clk);
        scl_drv = 1'b1;
        repeat (5) @(negedge clk);
      end else begin
        q(); q();
      end
      scl_drv = 1'b0; q();
    end
    sda_drv = 1'b1; q();
    scl_drv = 1'b1; q();
    acked = ~sda_line;
    q();
    scl_drv = 1'b0; q();
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] b);
    sda_drv = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      q(); q();
      scl_drv = 1'b1; q();
      b[i] = sda_line;
      q();
      scl_drv = 1'b0;
    end
    q();
    sda_drv = ack ? 1'b0 : 1'b1; q();
    scl_drv = 1'b1; q(); q();
    scl_drv = 1'b0; q();
    sda_drv = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; scl_drv = 1'b1; sda_drv = 1'b1; host_addr = '0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe: got %b expected 0", sda_oe); end
    checks++; if (wr_stb !== 1'b0) begin errors++; $display("FAIL reset_wr_stb: got %b expected 0", wr_stb); end
    checks++; if (wr_ptr !== 4'h0) begin errors++; $display("FAIL reset_wr_ptr: got %h expected 0", wr_ptr); end
    checks++; if (wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data: got %h expected 00", wr_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    for (int k = 0; k < 16; k++) begin
      host_addr = 4'(k); #1;
      checks++; if (host_data !== 8'h00) begin errors++; $display("FAIL reset_reg[%0d]: got %h expected 00", k, host_data); end
    end
  endtask

  task automatic test_write();
    logic a0, a1, a2, a3, bz;
    wr_log.delete();
    host_addr = 4'd3; cap_old = 8'hxx; cap_new = 8'hxx;
    i2c_start();
    write_byte(8'hA0, -1, a0);
    write_byte(8'h03, -1, a1);
    write_byte(8'hA5, -1, a2);
    write_byte(8'h5A, -1, a3);
    bz = busy;
    i2c_stop();
    checks++; if ({a0, a1, a2, a3} !== 4'b1111) begin errors++; $display("FAIL write_acks: got %b expected 1111", {a0, a1, a2, a3}); end
    checks++; if (bz !== 1'b1) begin errors++; $display("FAIL write_busy: got %b expected 1", bz); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_after_stop: got %b expected 0", busy); end
    checks++; if (wr_log.size() != 2) begin errors++; $display("FAIL write_stb_count: got %0d expected 2", wr_log.size()); end
    else begin
      checks++; if (wr_log[0] !== 12'h3A5) begin errors++; $display("FAIL write_stb0: got %h expected 3a5", wr_log[0]); end
      checks++; if (wr_log[1] !== 12'h45A) begin errors++; $display("FAIL write_stb1: got %h expected 45a", wr_log[1]); end
    end
    checks++; if (cap_old !== 8'h00) begin errors++; $display("FAIL write_host_old: got %h expected 00", cap_old); end
    checks++; if (cap_new !== 8'hA5) begin errors++; $display("FAIL write_host_new: got %h expected a5", cap_new); end
    host_addr = 4'd3; #1;
    checks++; if (host_data !== 8'hA5) begin errors++; $display("FAIL write_reg3: got %h expected a5", host_data); end
    host_addr = 4'd4; #1;
    checks++; if (host_data !== 8'h5A) begin errors++; $display("FAIL write_reg4: got %h expected 5a", host_data); end
  endtask

  task automatic test_read();
    logic a0, a1, a2;
    logic [7:0] d0, d1;
    wr_log.delete();
    i2c_start();
    write_byte(8'hA0, -1, a0);
    write_byte(8'h03, -1, a1);
    i2c_rstart();
    write_byte(8'hA1, -1, a2);
    read_byte(1'b1, d0);
    read_byte(1'b0, d1);
    q();
    checks++; if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL read_acks: got %b expected 111", {a0, a1, a2}); end
    checks++; if (d0 !== 8'hA5) begin errors++; $display("FAIL read_byte0: got %h expected a5", d0); end
    checks++; if (d1 !== 8'h5A) begin errors++; $display("FAIL read_byte1: got %h expected 5a", d1); end
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL read_release_after_nack: got %b expected 0", sda_oe); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL read_busy_wait: got %b expected 1", busy); end
    i2c_stop();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_busy_after_stop: got %b expected 0", busy); end
    checks++; if (wr_log.size() != 0) begin errors++; $display("FAIL read_no_writes: got %0d expected 0", wr_log.size()); end
  endtask

  task automatic test_wrong_addr();
    logic a0, a1, a2, bz;
    wr_log.delete();
    oe_seen = 1'b0;
    i2c_start();
    write_byte(8'hA2, -1, a0);
    write_byte(8'h03, -1, a1);
    write_byte(8'h77, -1, a2);
    bz = busy;
    i2c_stop();
    checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL wrong_addr_acks: got %b expected 000", {a0, a1, a2}); end
    checks++; if (oe_seen !== 1'b0) begin errors++; $display("FAIL wrong_addr_sda_oe: got %b expected 0", oe_seen); end
    checks++; if (bz !== 1'b0) begin errors++; $display("FAIL wrong_addr_busy: got %b expected 0", bz); end
    checks++; if (wr_log.size() != 0) begin errors++; $display("FAIL wrong_addr_writes: got %0d expected 0", wr_log.size()); end
    host_addr = 4'd3; #1;
    checks++; if (host_data !== 8'hA5) begin errors++; $display("FAIL wrong_addr_reg3: got %h expected a5", host_data); end
  endtask

  task automatic test_wrap();
    logic a0, a1, a2, a3;
    wr_log.delete();
    i2c_start();
    write_byte(8'hA0, -1, a0);
    write_byte(8'h0F, -1, a1);
    write_byte(8'h11, -1, a2);
    write_byte(8'h22, -1, a3);
    i2c_stop();
    checks++; if ({a0, a1, a2, a3} !== 4'b1111) begin errors++; $display("FAIL wrap_acks: got %b expected 1111", {a0, a1, a2, a3}); end
    host_addr = 4'd15; #1;
    checks++; if (host_data !== 8'h11) begin errors++; $display("FAIL wrap_reg15: got %h expected 11", host_data); end
    host_addr = 4'd0; #1;
    checks++; if (host_data !== 8'h22) begin errors++; $display("FAIL wrap_reg0: got %h expected 22", host_data); end
    checks++; if (wr_log.size() != 2) begin errors++; $display("FAIL wrap_stb_count: got %0d expected 2", wr_log.size()); end
    else begin
      checks++; if (wr_log[1] !== 12'h022) begin errors++; $display("FAIL wrap_stb1: got %h expected 022", wr_log[1]); end
    end
  endtask

  task automatic test_reset_mid();
    logic a0, a1, a2, a3, a4, a5;
    int   wait_cnt;
    i2c_start();
    write_byte(8'hA0, -1, a0);
    write_byte(8'h05, -1, a1);
    write_byte(8'h33, -1, a2);
    for (int i = 7; i >= 0; i--) begin
      sda_drv = 1'(8'h44 >> i); q();
      scl_drv = 1'b1; q(); q();
      scl_drv = 1'b0; q();
    end
    sda_drv = 1'b1;
    wait_cnt = 0;
    while (sda_oe !== 1'b1 && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    checks++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL rst_mid_ack_seen: got %b expected 1", sda_oe); end
    rst = 1'b1; #1;
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rst_mid_sda_oe: got %b expected 0", sda_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    for (int k = 0; k < 16; k++) begin
      host_addr = 4'(k); #1;
      checks++; if (host_data !== 8'h00) begin errors++; $display("FAIL rst_mid_reg[%0d]: got %h expected 00", k, host_data); end
    end
    @(negedge clk);
    rst = 1'b0;
    scl_drv = 1'b1; q();
    scl_drv = 1'b0; q();
    i2c_stop();
    wr_log.delete();
    i2c_start();
    write_byte(8'hA0, -1, a3);
    write_byte(8'h02, -1, a4);
    write_byte(8'hC3, -1, a5);
    i2c_stop();
    checks++; if ({a0, a1, a2, a3, a4, a5} !== 6'b111111) begin errors++; $display("FAIL rst_mid_acks: got %b expected 111111", {a0, a1, a2, a3, a4, a5}); end
    host_addr = 4'd2; #1;
    checks++; if (host_data !== 8'hC3) begin errors++; $display("FAIL rst_mid_reg2: got %h expected c3", host_data); end
    checks++; if (wr_log.size() != 1) begin errors++; $display("FAIL rst_mid_stb_count: got %0d expected 1", wr_log.size()); end
    else begin
      checks++; if (wr_log[0] !== 12'h2C3) begin errors++; $display("FAIL rst_mid_stb: got %h expected 2c3", wr_log[0]); end
    end
  endtask

`ifdef I2C_TARGET_REGFILE_FILTER_EN
  task automatic test_glitch();
    logic a0, a1, a2, a3;
    wr_log.delete();
    i2c_start();
    write_byte(8'hA0, -1, a0);
    write_byte(8'h08, -1, a1);
    write_byte(8'h96, 4, a2);
    write_byte(8'h3C, 6, a3);
    i2c_stop();
    checks++; if ({a0, a1, a2, a3} !== 4'b1111) begin errors++; $display("FAIL glitch_acks: got %b expected 1111", {a0, a1, a2, a3}); end
    host_addr = 4'd8; #1;
    checks++; if (host_data !== 8'h96) begin errors++; $display("FAIL glitch_reg8: got %h expected 96", host_data); end
    host_addr = 4'd9; #1;
    checks++; if (host_data !== 8'h3C) begin errors++; $display("FAIL glitch_reg9: got %h expected 3c", host_data); end
    checks++; if (wr_log.size() != 2) begin errors++; $display("FAIL glitch_stb_count: got %0d expected 2", wr_log.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wrong_addr();
    test_wrap();
    test_reset_mid();
`ifdef I2C_TARGET_REGFILE_FILTER_EN
    test_glitch();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
